ram_copy_engine: RTL and testbench

- Initiator for the 32x8 single-port data RAM. Drives its write-enable, address and write-data pins and samples its read-data pin.
- Performs block copy (RAM to RAM) and block fill (constant to RAM) on a single start pulse.
- Sits between the control unit and the data RAM, so the control unit does not sequence multi-word memory moves itself.

---
 rtl/ram_copy_engine.sv | 167 ++++++++++++++++
 tb/tb_ram_copy_engine.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_copy_engine.sv
// Block copy / block fill initiator for a 32x8 single-port RAM with combinational read.
// Optional running checksum of written words enabled by defining RAM_COPY_CHECKSUM_EN.
`timescale 1ns/1ps

module ram_copy_engine #(
    parameter int AW = 5,
    parameter int DW = 8,
    parameter int LW = 6
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          mode_i,
    input  logic [AW-1:0] src_i,
    input  logic [AW-1:0] dst_i,
    input  logic [LW-1:0] len_i,
    input  logic [DW-1:0] fill_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic          ram_wen_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_din_o,
    input  logic [DW-1:0] ram_dout_i
`ifdef RAM_COPY_CHECKSUM_EN
    ,
    output logic [DW-1:0] sum_o
`endif
);

    localparam logic [LW-1:0] DEPTH = LW'(2 ** AW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_FILL,
        S_DONE,
        S_ERR
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [LW-1:0] r_rem;
    logic [DW-1:0] r_hold;
    logic [AW-1:0] r_addr;
    logic          r_wen;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    // RAM-side outputs are registered: each transition loads the values the next state presents.
    // r_hold doubles as the write-data register (read word in copy, fill value in fill).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_rem   <= '0;
            r_hold  <= '0;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                    r_wen  <= 1'b0;
                    r_addr <= '0;
                    r_hold <= '0;
                    if (start_i) begin
                        r_src  <= src_i;
                        r_dst  <= dst_i;
                        r_rem  <= len_i;
                        r_busy <= 1'b1;
                        if (len_i > DEPTH) begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end else if (len_i == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (!mode_i) begin
                            r_state <= S_RD;
                            r_addr  <= src_i;
                        end else begin
                            r_state <= S_FILL;
                            r_addr  <= dst_i;
                            r_hold  <= fill_i;
                            r_wen   <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    r_hold  <= ram_dout_i;
                    r_src   <= r_src + 1'b1;
                    r_addr  <= r_dst;
                    r_wen   <= 1'b1;
                    r_state <= S_WR;
                end
                S_WR, S_FILL: begin
                    r_dst <= r_dst + 1'b1;
                    r_rem <= r_rem - 1'b1;
                    if (r_rem == LW'(1)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_wen   <= 1'b0;
                        r_addr  <= '0;
                        r_hold  <= '0;
                    end else if (r_state == S_WR) begin
                        r_state <= S_RD;
                        r_wen   <= 1'b0;
                        r_addr  <= r_src;
                    end else begin
                        r_addr <= r_dst + 1'b1;
                    end
                end
                S_DONE, S_ERR: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_wen   <= 1'b0;
                    r_addr  <= '0;
                    r_hold  <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_wen   <= 1'b0;
                    r_addr  <= '0;
                    r_hold  <= '0;
                end
            endcase
        end
    end

    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign err_o      = r_err;
    assign ram_wen_o  = r_wen;
    assign ram_addr_o = r_addr;
    assign ram_din_o  = r_hold;

`ifdef RAM_COPY_CHECKSUM_EN
    logic [DW-1:0] r_sum;

    // Any start seen in IDLE clears the sum, including rejected ones.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sum <= '0;
        end else if (r_state == S_IDLE && start_i) begin
            r_sum <= '0;
        end else if (r_wen) begin
            r_sum <= r_sum + r_hold;
        end
    end

    assign sum_o = r_sum;
`endif

endmodule

// File: tb/tb_ram_copy_engine.sv
// Self-checking bench for ram_copy_engine: RAM model, reference copy/fill model, write scoreboard.
// Build with RAM_COPY_CHECKSUM_EN defined to also check sum_o.
`timescale 1ns/1ps

module tb_ram_copy_engine;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int LW = 6;
    localparam int W  = AW + DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic          mode_i = 1'b0;
    logic [AW-1:0] src_i = '0;
    logic [AW-1:0] dst_i = '0;
    logic [LW-1:0] len_i = '0;
    logic [DW-1:0] fill_i = '0;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic          ram_wen_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_din_o;
    logic [DW-1:0] ram_dout;
`ifdef RAM_COPY_CHECKSUM_EN
    logic [DW-1:0] sum_o;
    logic [DW-1:0] g_sum;
    logic [DW-1:0] g_exp_sum;
`endif

    logic [DW-1:0] mem[32];
    logic [DW-1:0] exp_mem[32];
    logic [W-1:0]  exp_q[$];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    int n_checks = 0;
    int n_fail   = 0;

    int g_done_cyc, g_err_cyc, g_wen_cnt, g_done_cnt, g_err_cnt, g_busy1;

    ram_copy_engine #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start_i),
        .mode_i     (mode_i),
        .src_i      (src_i),
        .dst_i      (dst_i),
        .len_i      (len_i),
        .fill_i     (fill_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .ram_wen_o  (ram_wen_o),
        .ram_addr_o (ram_addr_o),
        .ram_din_o  (ram_din_o),
`ifdef RAM_COPY_CHECKSUM_EN
        .sum_o      (sum_o),
`endif
        .ram_dout_i (ram_dout)
    );

    // ---------------- clock / RAM model ----------------
    always #5 clk = ~clk;

    assign ram_dout = mem[ram_addr_o];

    always @(posedge clk) begin
        if (ram_wen_o === 1'b1) mem[ram_addr_o] <= ram_din_o;
        else if (pl_en) mem[pl_addr] <= pl_data;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard: every RAM write must match the next expected write ----------------
    always @(negedge clk) begin
        if (ram_wen_o !== 1'b0) begin
            logic [W-1:0] e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_write: got addr=%0h data=%0h wen=%b expected no write",
                         ram_addr_o, ram_din_o, ram_wen_o);
            end else begin
                e = exp_q.pop_front();
                if ({ram_addr_o, ram_din_o} !== e) begin
                    n_fail++;
                    $display("FAIL sb_write: got addr=%0h data=%0h expected addr=%0h data=%0h",
                             ram_addr_o, ram_din_o, e[W-1:DW], e[DW-1:0]);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic model_op(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input int l, input logic [DW-1:0] f);
        logic [AW-1:0] a;
        logic [AW-1:0] sa;
        logic [DW-1:0] v;
`ifdef RAM_COPY_CHECKSUM_EN
        g_exp_sum = '0;
`endif
        if (l < 1 || l > 32) return;
        for (int i = 0; i < l; i++) begin
            a  = d + AW'(i);
            sa = s + AW'(i);
            v  = m ? f : exp_mem[sa];
            exp_mem[a] = v;
            exp_q.push_back({a, v});
`ifdef RAM_COPY_CHECKSUM_EN
            g_exp_sum = g_exp_sum + v;
`endif
        end
    endtask

    function automatic int mem_diff();
        int b = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== exp_mem[i]) b++;
        return b;
    endfunction

    // ---------------- drivers ----------------
    task automatic preload_random();
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            pl_en   = 1'b1;
            pl_addr = AW'(a);
            pl_data = DW'($urandom);
            exp_mem[a] = pl_data;
        end
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic poke(input int a, input logic [DW-1:0] v);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = AW'(a);
        pl_data = v;
        exp_mem[a] = v;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Starts one operation, models it, then watches a fixed window of cycles after the start edge.
    task automatic run_op(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input int l, input logic [DW-1:0] f, input int pulse_cyc);
        int window;
        window = 2 * l + 6;
        g_done_cyc = -1; g_err_cyc = -1; g_wen_cnt = 0; g_done_cnt = 0; g_err_cnt = 0; g_busy1 = 0;
        model_op(m, s, d, l, f);
        @(negedge clk);
        mode_i = m; src_i = s; dst_i = d; len_i = LW'(l); fill_i = f; start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        mode_i = 1'($urandom); src_i = AW'($urandom); dst_i = AW'($urandom);
        len_i = LW'($urandom); fill_i = DW'($urandom);
        for (int cyc = 1; cyc <= window; cyc++) begin
            @(negedge clk);
            if (cyc == 1) g_busy1 = int'(busy_o);
            if (ram_wen_o === 1'b1) g_wen_cnt++;
            if (done_o === 1'b1) begin
                g_done_cnt++;
                if (g_done_cyc < 0) begin
                    g_done_cyc = cyc;
`ifdef RAM_COPY_CHECKSUM_EN
                    g_sum = sum_o;
`endif
                end
            end
            if (err_o === 1'b1) begin
                g_err_cnt++;
                if (g_err_cyc < 0) g_err_cyc = cyc;
            end
            if (cyc == pulse_cyc) begin
                start_i = 1'b1; mode_i = 1'b1; dst_i = '0; len_i = LW'(5); fill_i = 8'hEE;
            end else begin
                start_i = 1'b0;
            end
        end
        start_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", done_o); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", err_o); end
        n_checks++; if (ram_wen_o !== 1'b0) begin n_fail++; $display("FAIL rst_wen: got %b expected 0", ram_wen_o); end
        n_checks++; if (ram_addr_o !== '0) begin n_fail++; $display("FAIL rst_addr: got %0h expected 0", ram_addr_o); end
        n_checks++; if (ram_din_o !== '0) begin n_fail++; $display("FAIL rst_din: got %0h expected 0", ram_din_o); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if ({busy_o, done_o, err_o, ram_wen_o} !== 4'b0) begin
            n_fail++; $display("FAIL idle_flags: got %b expected 0000", {busy_o, done_o, err_o, ram_wen_o});
        end
    endtask

    task automatic test_copy();
        preload_random();
        poke(2, 8'h11); poke(3, 8'h22); poke(4, 8'h33); poke(5, 8'h44);
        run_op(1'b0, 5'h02, 5'h10, 4, 8'h00, 0);
        n_checks++; if (g_busy1 !== 1) begin n_fail++; $display("FAIL copy_busy: got %0d expected 1", g_busy1); end
        n_checks++; if (g_done_cyc !== 9) begin n_fail++; $display("FAIL copy_done_cyc: got %0d expected 9", g_done_cyc); end
        n_checks++; if (g_done_cnt !== 1) begin n_fail++; $display("FAIL copy_done_cnt: got %0d expected 1", g_done_cnt); end
        n_checks++; if (g_wen_cnt !== 4) begin n_fail++; $display("FAIL copy_wen_cnt: got %0d expected 4", g_wen_cnt); end
        n_checks++; if ({mem[16], mem[17], mem[18], mem[19]} !== 32'h11223344) begin
            n_fail++; $display("FAIL copy_dst: got %0h expected 11223344", {mem[16], mem[17], mem[18], mem[19]});
        end
        n_checks++; if ({mem[2], mem[3], mem[4], mem[5]} !== 32'h11223344) begin
            n_fail++; $display("FAIL copy_src: got %0h expected 11223344", {mem[2], mem[3], mem[4], mem[5]});
        end
        n_checks++; if (mem_diff() !== 0) begin n_fail++; $display("FAIL copy_image: got %0d bad words expected 0", mem_diff()); end
    endtask

    task automatic test_fill_wrap();
        logic [DW-1:0] keep;
        keep = mem[2];
        run_op(1'b1, 5'h00, 5'h1E, 4, 8'hA5, 0);
        n_checks++; if (g_done_cyc !== 5) begin n_fail++; $display("FAIL fill_done_cyc: got %0d expected 5", g_done_cyc); end
        n_checks++; if (g_wen_cnt !== 4) begin n_fail++; $display("FAIL fill_wen_cnt: got %0d expected 4", g_wen_cnt); end
        n_checks++; if ({mem[30], mem[31], mem[0], mem[1]} !== 32'hA5A5A5A5) begin
            n_fail++; $display("FAIL fill_wrap: got %0h expected a5a5a5a5", {mem[30], mem[31], mem[0], mem[1]});
        end
        n_checks++; if (mem[2] !== keep) begin n_fail++; $display("FAIL fill_untouched: got %0h expected %0h", mem[2], keep); end
    endtask

    task automatic test_len0();
        run_op(1'b0, 5'h04, 5'h08, 0, 8'h00, 0);
        n_checks++; if (g_done_cyc !== 1) begin n_fail++; $display("FAIL len0_done_cyc: got %0d expected 1", g_done_cyc); end
        n_checks++; if (g_wen_cnt !== 0) begin n_fail++; $display("FAIL len0_wen: got %0d expected 0", g_wen_cnt); end
        n_checks++; if (g_err_cnt !== 0) begin n_fail++; $display("FAIL len0_err: got %0d expected 0", g_err_cnt); end
    endtask

    task automatic test_len33();
        run_op(1'b1, 5'h00, 5'h00, 33, 8'h5A, 0);
        n_checks++; if (g_err_cyc !== 1) begin n_fail++; $display("FAIL len33_err_cyc: got %0d expected 1", g_err_cyc); end
        n_checks++; if (g_err_cnt !== 1) begin n_fail++; $display("FAIL len33_err_cnt: got %0d expected 1", g_err_cnt); end
        n_checks++; if (g_done_cnt !== 0) begin n_fail++; $display("FAIL len33_done: got %0d expected 0", g_done_cnt); end
        n_checks++; if (g_wen_cnt !== 0) begin n_fail++; $display("FAIL len33_wen: got %0d expected 0", g_wen_cnt); end
        n_checks++; if (mem_diff() !== 0) begin n_fail++; $display("FAIL len33_image: got %0d bad words expected 0", mem_diff()); end
    endtask

    task automatic test_len32_fill();
        int bad = 0;
        run_op(1'b1, 5'h00, 5'h07, 32, 8'h3C, 0);
        for (int i = 0; i < 32; i++) if (mem[i] !== 8'h3C) bad++;
        n_checks++; if (g_done_cyc !== 33) begin n_fail++; $display("FAIL len32_done_cyc: got %0d expected 33", g_done_cyc); end
        n_checks++; if (g_wen_cnt !== 32) begin n_fail++; $display("FAIL len32_wen: got %0d expected 32", g_wen_cnt); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL len32_all: got %0d words not 3c expected 0", bad); end
    endtask

    task automatic test_start_busy();
        preload_random();
        run_op(1'b0, 5'h08, 5'h18, 4, 8'h00, 3);
        n_checks++; if (g_done_cyc !== 9) begin n_fail++; $display("FAIL busy_done_cyc: got %0d expected 9", g_done_cyc); end
        n_checks++; if (g_done_cnt !== 1) begin n_fail++; $display("FAIL busy_done_cnt: got %0d expected 1", g_done_cnt); end
        n_checks++; if (g_wen_cnt !== 4) begin n_fail++; $display("FAIL busy_wen: got %0d expected 4", g_wen_cnt); end
        n_checks++; if (mem_diff() !== 0) begin n_fail++; $display("FAIL busy_image: got %0d bad words expected 0", mem_diff()); end
    endtask

    task automatic test_reset_mid();
        int dcnt = 0;
        preload_random();
        model_op(1'b0, 5'h03, 5'h14, 2, 8'h00);
        @(negedge clk);
        mode_i = 1'b0; src_i = 5'h03; dst_i = 5'h14; len_i = LW'(8); start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            @(negedge clk);
            if (done_o === 1'b1) dcnt++;
            if (cyc == 5) rst = 1'b1;
            if (cyc == 6) begin
                rst = 1'b0;
                n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy_o); end
                n_checks++; if (ram_wen_o !== 1'b0) begin n_fail++; $display("FAIL rmid_wen: got %b expected 0", ram_wen_o); end
            end
        end
        n_checks++; if (dcnt !== 0) begin n_fail++; $display("FAIL rmid_done: got %0d expected 0", dcnt); end
        n_checks++; if (mem_diff() !== 0) begin n_fail++; $display("FAIL rmid_image: got %0d bad words expected 0", mem_diff()); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 30; k++) begin
            logic m;
            int l, exp_done;
            m = 1'($urandom);
            l = ($urandom_range(0, 9) == 0) ? 33 : int'($urandom_range(0, 32));
            run_op(m, AW'($urandom), AW'($urandom), l, DW'($urandom), 0);
            if (l > 32) exp_done = -1;
            else if (l == 0) exp_done = 1;
            else exp_done = m ? l + 1 : 2 * l + 1;
            n_checks++; if (g_done_cyc !== exp_done) begin
                n_fail++; $display("FAIL rnd_done_cyc: got %0d expected %0d (mode %0d len %0d)", g_done_cyc, exp_done, m, l);
            end
            n_checks++; if (g_err_cnt !== ((l > 32) ? 1 : 0)) begin
                n_fail++; $display("FAIL rnd_err: got %0d expected %0d (len %0d)", g_err_cnt, (l > 32) ? 1 : 0, l);
            end
            n_checks++; if (g_wen_cnt !== ((l > 32) ? 0 : l)) begin
                n_fail++; $display("FAIL rnd_wen: got %0d expected %0d", g_wen_cnt, (l > 32) ? 0 : l);
            end
            n_checks++; if (mem_diff() !== 0) begin n_fail++; $display("FAIL rnd_image: got %0d bad words expected 0", mem_diff()); end
`ifdef RAM_COPY_CHECKSUM_EN
            if (l >= 1 && l <= 32) begin
                n_checks++; if (g_sum !== g_exp_sum) begin
                    n_fail++; $display("FAIL rnd_sum: got %0h expected %0h", g_sum, g_exp_sum);
                end
            end
`endif
        end
    endtask

`ifdef RAM_COPY_CHECKSUM_EN
    task automatic test_checksum();
        run_op(1'b1, 5'h00, 5'h09, 3, 8'h90, 0);
        n_checks++; if (g_sum !== 8'hB0) begin n_fail++; $display("FAIL sum_at_done: got %0h expected b0", g_sum); end
        n_checks++; if (sum_o !== 8'hB0) begin n_fail++; $display("FAIL sum_hold: got %0h expected b0", sum_o); end
    endtask
`endif

    task automatic test_queue_drained();
        n_checks++; if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL sb_drain: got %0d pending writes expected 0", exp_q.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_copy();
        test_fill_wrap();
        test_len0();
        test_len33();
        test_len32_fill();
        test_start_busy();
        test_reset_mid();
        test_random();
`ifdef RAM_COPY_CHECKSUM_EN
        test_checksum();
`endif
        test_queue_drained();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
